// File: rtl/max_subtract_64.sv
// Per-lane x - max stage that follows max_tree_64 in the softmax approximation datapath.
// Two registered stages with a global enable; results are floored at SAT_MIN and invalid lanes are forced to SAT_MIN.
module max_subtract_64 #(
    parameter int DATA_W  = 16,
    parameter int SAT_MIN = -32768
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_valid_max,
    input  logic [1:0]             i_length_mode,
    input  logic [63:0]            i_valid,
    input  logic [64*DATA_W-1:0]   i_in_flat,
    input  logic [DATA_W-1:0]      i_max64_0,
    input  logic [DATA_W-1:0]      i_max32_0,
    input  logic [DATA_W-1:0]      i_max32_1,
    input  logic [DATA_W-1:0]      i_max16_0,
    input  logic [DATA_W-1:0]      i_max16_1,
    input  logic [DATA_W-1:0]      i_max16_2,
    input  logic [DATA_W-1:0]      i_max16_3,
    output logic                   o_valid,
    output logic [64*DATA_W-1:0]   o_sub_flat,
    output logic [1:0]             o_length_mode_byp,
    output logic [63:0]            o_valid_byp
);

    localparam int LANES = 64;
    localparam logic [DATA_W-1:0]        SAT_VAL = DATA_W'(SAT_MIN);
    localparam logic signed [DATA_W:0]   SAT_EXT = (DATA_W+1)'(SAT_MIN);

    logic                       s1_valid;
    logic [LANES*DATA_W-1:0]    s1_data;
    logic [LANES-1:0]           s1_lane_valid;
    logic [1:0]                 s1_mode;
    logic [DATA_W-1:0]          s1_max64;
    logic [1:0][DATA_W-1:0]     s1_max32;
    logic [3:0][DATA_W-1:0]     s1_max16;

    logic [LANES*DATA_W-1:0]    sub_next;
    logic [DATA_W-1:0]          max_sel;
    logic [DATA_W-1:0]          x_lane;
    logic signed [DATA_W:0]     diff;
    logic [DATA_W-1:0]          res;

    // Stage 1: capture the vector and its maxima only when a new one arrives so idle cycles do not toggle the data path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_lane_valid <= '0;
            s1_mode       <= '0;
            s1_max64      <= '0;
            s1_max32      <= '0;
            s1_max16      <= '0;
        end else if (i_en) begin
            s1_valid <= i_valid_max;
            if (i_valid_max) begin
                s1_data       <= i_in_flat;
                s1_lane_valid <= i_valid;
                s1_mode       <= i_length_mode;
                s1_max64      <= i_max64_0;
                s1_max32      <= {i_max32_1, i_max32_0};
                s1_max16      <= {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
            end
        end
    end

    // Mode 3 is reserved and falls through to the single 64-lane segment.
    always_comb begin
        sub_next = '0;
        max_sel  = '0;
        x_lane   = '0;
        diff     = '0;
        res      = '0;
        for (int i = 0; i < LANES; i++) begin
            case (s1_mode)
                2'd1:    max_sel = s1_max32[i[5]];
                2'd2:    max_sel = s1_max16[i[5:4]];
                default: max_sel = s1_max64;
            endcase
            x_lane = s1_data[i*DATA_W +: DATA_W];
            diff   = {x_lane[DATA_W-1], x_lane} - {max_sel[DATA_W-1], max_sel};
            // A positive difference means upstream handed us a max smaller than a lane; clamp to 0.
            if (!s1_lane_valid[i] || (diff < SAT_EXT)) begin
                res = SAT_VAL;
            end else if (!diff[DATA_W] && (diff != '0)) begin
                res = '0;
            end else begin
                res = diff[DATA_W-1:0];
            end
            sub_next[i*DATA_W +: DATA_W] = res;
        end
    end

    // Stage 2: register results and bypass fields; outputs hold between vectors and during stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid           <= 1'b0;
            o_sub_flat        <= '0;
            o_length_mode_byp <= '0;
            o_valid_byp       <= '0;
        end else if (i_en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_sub_flat        <= sub_next;
                o_length_mode_byp <= s1_mode;
                o_valid_byp       <= s1_lane_valid;
            end
        end
    end

endmodule

// File: tb/tb_max_subtract_64.sv
// Scoreboard bench for max_subtract_64: an integer reference model queues expected results at drive time,
// and a negedge monitor pops them when an enabled edge produces o_valid.
module tb_max_subtract_64;

    localparam int DATA_W = 16;
    localparam int N      = 64;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic                  i_en = 1'b0;
    logic                  i_valid_max = 1'b0;
    logic [1:0]            i_length_mode = '0;
    logic [63:0]           i_valid = '0;
    logic [N*DATA_W-1:0]   i_in_flat = '0;
    logic [DATA_W-1:0]     i_max64_0 = '0;
    logic [DATA_W-1:0]     i_max32_0 = '0;
    logic [DATA_W-1:0]     i_max32_1 = '0;
    logic [DATA_W-1:0]     i_max16_0 = '0;
    logic [DATA_W-1:0]     i_max16_1 = '0;
    logic [DATA_W-1:0]     i_max16_2 = '0;
    logic [DATA_W-1:0]     i_max16_3 = '0;
    logic                  o_valid;
    logic [N*DATA_W-1:0]   o_sub_flat;
    logic [1:0]            o_length_mode_byp;
    logic [63:0]           o_valid_byp;

    max_subtract_64 #(.DATA_W(DATA_W), .SAT_MIN(-32768)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid_max(i_valid_max),
        .i_length_mode(i_length_mode), .i_valid(i_valid), .i_in_flat(i_in_flat),
        .i_max64_0(i_max64_0), .i_max32_0(i_max32_0), .i_max32_1(i_max32_1),
        .i_max16_0(i_max16_0), .i_max16_1(i_max16_1), .i_max16_2(i_max16_2), .i_max16_3(i_max16_3),
        .o_valid(o_valid), .o_sub_flat(o_sub_flat),
        .o_length_mode_byp(o_length_mode_byp), .o_valid_byp(o_valid_byp)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0]            mode;
        logic [63:0]           vbyp;
        logic [N*DATA_W-1:0]   sub;
        logic [2:0]            nspot;
        logic [3:0][5:0]       sl;
        logic [3:0][15:0]      sv;
    } exp_t;

    exp_t sb[$];

    int               x[N];
    logic [63:0]      lane_v;
    logic [1:0]       mode;
    int               m64;
    int               m32[2];
    int               m16[4];
    int               nspot = 0;
    logic [3:0][5:0]  spot_lane = '0;
    logic [3:0][15:0] spot_val = '0;

    int num_vectors = 0;
    int num_fail = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_vectors++;
        if (obs !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic logic [N*DATA_W-1:0] model();
        logic [N*DATA_W-1:0] r;
        int m, d;
        r = '0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                2'd1:    m = m32[i/32];
                2'd2:    m = m16[i/16];
                default: m = m64;
            endcase
            d = x[i] - m;
            if (!lane_v[i])     d = -32768;
            else if (d < -32768) d = -32768;
            else if (d > 0)      d = 0;
            r[i*DATA_W +: DATA_W] = d[DATA_W-1:0];
        end
        return r;
    endfunction

    task automatic addSpot(input int lane, input int val);
        spot_lane[nspot] = 6'(lane);
        spot_val[nspot]  = 16'(val);
        nspot++;
    endtask

    task automatic applyStimulus(input logic en, input logic vmax);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_en          = en;
        i_valid_max   = vmax;
        i_length_mode = mode;
        i_valid       = lane_v;
        for (int i = 0; i < N; i++) i_in_flat[i*DATA_W +: DATA_W] = DATA_W'(x[i]);
        i_max64_0 = DATA_W'(m64);
        i_max32_0 = DATA_W'(m32[0]);
        i_max32_1 = DATA_W'(m32[1]);
        i_max16_0 = DATA_W'(m16[0]);
        i_max16_1 = DATA_W'(m16[1]);
        i_max16_2 = DATA_W'(m16[2]);
        i_max16_3 = DATA_W'(m16[3]);
        if (en && vmax) begin
            e.mode  = mode;
            e.vbyp  = lane_v;
            e.sub   = model();
            e.nspot = 3'(nspot);
            e.sl    = spot_lane;
            e.sv    = spot_val;
            sb.push_back(e);
        end
        nspot = 0;
    endtask

    task automatic applyReset();
        @(posedge i_clk);
        #1;
        i_rst       = 1'b1;
        i_valid_max = 1'b0;
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic setVecT1();
        mode = 2'd0; lane_v = '1; m64 = 500; m32 = '{0, 0}; m16 = '{0, 0, 0, 0};
        for (int i = 0; i < N; i++) x[i] = i;
        x[0] = 500;
        addSpot(0, 0); addSpot(1, -499); addSpot(63, -437);
    endtask

    task automatic setVecMode2();
        mode = 2'd2; lane_v = '1; m64 = 1000; m32 = '{1000, 1000}; m16 = '{-85, -69, -53, -37};
        for (int i = 0; i < N; i++) x[i] = -100 + i;
        addSpot(0, -15); addSpot(16, -15); addSpot(47, 0); addSpot(63, 0);
    endtask

    task automatic setVecRandom();
        mode   = 2'($urandom_range(0, 3));
        lane_v = {$urandom, $urandom};
        m64    = $signed(16'($urandom));
        for (int k = 0; k < 2; k++) m32[k] = $signed(16'($urandom));
        for (int k = 0; k < 4; k++) m16[k] = $signed(16'($urandom));
        for (int i = 0; i < N; i++) x[i] = $signed(16'($urandom));
    endtask

    // Monitor: classify each edge by the enable/reset that was sampled at it.
    logic              last_en = 1'b0;
    logic              last_rst = 1'b1;
    logic              prev_valid = 1'b0;
    logic [N*DATA_W-1:0] prev_sub = '0;

    always @(negedge i_clk) begin
        exp_t e;
        if (last_rst) begin
            checkOutput("rst_valid", 64'(o_valid), 64'd0);
            checkOutput("rst_sub_lane0", 64'(o_sub_flat[15:0]), 64'd0);
            checkOutput("rst_byp", o_valid_byp, 64'd0);
        end else if (!last_en) begin
            checkOutput("stall_valid", 64'(o_valid), 64'(prev_valid));
            checkOutput("stall_sub_lo", o_sub_flat[63:0], prev_sub[63:0]);
        end else if (o_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 64'(o_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("mode_byp", 64'(o_length_mode_byp), 64'(e.mode));
                checkOutput("valid_byp", o_valid_byp, e.vbyp);
                for (int i = 0; i < N; i++)
                    checkOutput($sformatf("lane%0d", i), 64'(o_sub_flat[i*DATA_W +: DATA_W]),
                                64'(e.sub[i*DATA_W +: DATA_W]));
                for (int k = 0; k < int'(e.nspot); k++)
                    checkOutput($sformatf("spot_lane%0d", e.sl[k]),
                                64'(o_sub_flat[int'(e.sl[k])*DATA_W +: DATA_W]), 64'(e.sv[k]));
            end
        end
        prev_valid = o_valid;
        prev_sub   = o_sub_flat;
        last_en    = i_en;
        last_rst   = i_rst;
    end

    initial begin
        mode = '0; lane_v = '0; m64 = 0; m32 = '{0, 0}; m16 = '{0, 0, 0, 0};
        for (int i = 0; i < N; i++) x[i] = 0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Mode 0 basic vector
        setVecT1();
        applyStimulus(1, 1);
        repeat (3) applyStimulus(1, 0);

        // Mode 1 segments
        mode = 2'd1; lane_v = '1; m64 = -1000; m32 = '{31, 63}; m16 = '{0, 0, 0, 0};
        for (int i = 0; i < N; i++) x[i] = i;
        addSpot(0, -31); addSpot(31, 0); addSpot(32, -31); addSpot(63, 0);
        applyStimulus(1, 1);
        repeat (3) applyStimulus(1, 0);

        // Mode 2 segments
        setVecMode2();
        applyStimulus(1, 1);
        repeat (3) applyStimulus(1, 0);

        // Saturation floor and invalid lane
        mode = 2'd0; lane_v = '1; lane_v[9] = 1'b0; m64 = 32767;
        for (int i = 0; i < N; i++) x[i] = i;
        x[7] = -32768;
        addSpot(7, -32768); addSpot(9, -32768); addSpot(0, -32767); addSpot(63, -32704);
        applyStimulus(1, 1);

        // Reserved mode 3 behaves as mode 0; lanes above the max clamp to 0
        mode = 2'd3; lane_v = '1; m64 = 10; m32 = '{-5000, -5000}; m16 = '{-5000, -5000, -5000, -5000};
        for (int i = 0; i < N; i++) x[i] = i;
        addSpot(0, -10); addSpot(10, 0); addSpot(11, 0); addSpot(63, 0);
        applyStimulus(1, 1);
        repeat (3) applyStimulus(1, 0);

        // Back-to-back vectors
        setVecT1();
        applyStimulus(1, 1);
        setVecMode2();
        applyStimulus(1, 1);
        repeat (3) applyStimulus(1, 0);

        // Stall with o_valid high, including an ignored vector while disabled
        setVecT1();
        applyStimulus(1, 1);
        setVecMode2();
        applyStimulus(1, 1);
        applyStimulus(0, 0);
        setVecRandom();
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        repeat (3) applyStimulus(1, 0);

        // Reset mid-flight, then a clean vector afterwards
        setVecT1();
        applyStimulus(1, 1);
        applyReset();
        repeat (3) applyStimulus(1, 0);
        setVecMode2();
        applyStimulus(1, 1);
        repeat (3) applyStimulus(1, 0);

        // Random vectors with random enable
        for (int n = 0; n < 24; n++) begin
            setVecRandom();
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 20 && sb.size() != 0; c++) applyStimulus(1, 0);
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_fail);
        $finish;
    end

endmodule
